cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_line_store.sv | 37 +++
 rtl/cache_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller:
// default geometry and the FSM state encoding.
package cache_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 8;
   localparam int INDEX_W_DEF = 7;
   localparam int CNT_W_DEF   = 16;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_LOOKUP = 3'd1;
   localparam logic [ST_W-1:0] ST_MEM_RD = 3'd2;
   localparam logic [ST_W-1:0] ST_MEM_WR = 3'd3;
   localparam logic [ST_W-1:0] ST_RESP   = 3'd4;
   localparam logic [ST_W-1:0] ST_FLUSH  = 3'd5;

endpackage

// File: rtl/cache_line_store.sv
// Data and tag storage for the cache lines. One asynchronous read port,
// one synchronous write port, no reset: line validity is tracked by the
// controller, so stale contents here are harmless.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF
)(
   input  logic               clk_1,
   input  logic [INDEX_W-1:0] i_rd_idx,
   output logic [DATA_W-1:0]  o_rd_data,
   output logic [TAG_W-1:0]   o_rd_tag,
   input  logic               i_we,
   input  logic [INDEX_W-1:0] i_wr_idx,
   input  logic [DATA_W-1:0]  i_wr_data,
   input  logic [TAG_W-1:0]   i_wr_tag
);

   localparam int LINES = 2 ** INDEX_W;

   logic [DATA_W-1:0] r_data [LINES];
   logic [TAG_W-1:0]  r_tag  [LINES];

   assign o_rd_data = r_data[i_rd_idx];
   assign o_rd_tag  = r_tag[i_rd_idx];

   // Line fill / write-allocate update.
   always_ff @(posedge clk_1) begin
      if (i_we) begin
         r_data[i_wr_idx] <= i_wr_data;
         r_tag[i_wr_idx]  <= i_wr_tag;
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache controller.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for flush or cpu_req; latches the request
// LOOKUP    | compare tag/valid, register hit, pick next step
// MEM_RD    | read miss: fetch line from backing memory until mem_ack
// MEM_WR    | write: write through to backing memory until mem_ack
// RESP      | one-cycle cpu_ready pulse, update statistics
// FLUSH     | clear all valid bits, back to IDLE
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
)(
   input  logic              clk_1,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic              busy,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 2 ** INDEX_W;

   logic [ST_W-1:0]   r_state;
   logic [LINES-1:0]  r_valid;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_hit;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [DATA_W-1:0]  w_rd_data;
   logic [TAG_W-1:0]   w_rd_tag;
   logic               w_lookup_hit;
   logic               w_st_we;
   logic [DATA_W-1:0]  w_st_data;

   assign w_idx        = r_addr[INDEX_W-1:0];
   assign w_tag        = r_addr[ADDR_W-1:INDEX_W];
   assign w_lookup_hit = r_valid[w_idx] && (w_rd_tag == w_tag);

   // The store is only written on the acknowledged edge, so a reset that
   // lands before mem_ack leaves the line untouched.
   assign w_st_we   = mem_ack && ((r_state == ST_MEM_RD) || (r_state == ST_MEM_WR));
   assign w_st_data = (r_state == ST_MEM_RD) ? mem_rdata : r_wdata;

   cache_line_store #(
      .DATA_W  (DATA_W),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_store (
      .clk_1     (clk_1),
      .i_rd_idx  (w_idx),
      .o_rd_data (w_rd_data),
      .o_rd_tag  (w_rd_tag),
      .i_we      (w_st_we),
      .i_wr_idx  (w_idx),
      .i_wr_data (w_st_data),
      .i_wr_tag  (w_tag)
   );

   // Handshake outputs come from state alone; no CPU-side input reaches them.
   assign cpu_ready = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign mem_req   = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
   assign mem_we    = (r_state == ST_MEM_WR);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu_rdata = r_rdata;
   assign cpu_hit   = r_hit;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

   // Controller FSM, request latch, valid bits and read-data register.
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_valid <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_hit   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  r_state <= ST_FLUSH;
               end else if (cpu_req) begin
                  r_we    <= cpu_we;
                  r_addr  <= cpu_addr;
                  r_wdata <= cpu_wdata;
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               r_hit <= w_lookup_hit;
               if (r_we) begin
                  r_state <= ST_MEM_WR;
               end else if (w_lookup_hit) begin
                  r_rdata <= w_rd_data;
                  r_state <= ST_RESP;
               end else begin
                  r_state <= ST_MEM_RD;
               end
            end
            ST_MEM_RD: begin
               if (mem_ack) begin
                  r_valid[w_idx] <= 1'b1;
                  r_rdata        <= mem_rdata;
                  r_state        <= ST_RESP;
               end
            end
            ST_MEM_WR: begin
               if (mem_ack) begin
                  r_valid[w_idx] <= 1'b1;
                  r_state        <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            ST_FLUSH: begin
               r_valid <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating hit/miss statistics, bumped once per completed access.
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == ST_RESP) begin
         if (r_hit) begin
            if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         end else begin
            if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

endmodule
